branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined CPU's fetch stage.
- IF presents the fetch PC each cycle and receives a predicted next PC in the same cycle.
- EXECUTION reports resolved branches and jumps through an update port.
- The block also keeps saturating statistics counters for the update stream and for mispredictions.

Parameters:
XLEN, 32, address/data width in bits.
ENTRIES, 16, number of table entries; power of two, minimum 2.
IDX_W, log2(ENTRIES), index width; derived, not overridden.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  global enable; when 0, all state is frozen and lookups still operate.
clear  in  1  synchronous invalidate of all entries.
fetch_pc  in  XLEN  PC being fetched.
hit  out  1  fetch_pc matches a valid entry.
pred_taken  out  1  hit and counter[1]==1.
pred_pc  out  XLEN  predicted next PC.
upd_valid  in  1  a resolved branch/jump is present in EX this cycle.
upd_pc  in  XLEN  PC of the resolved instruction.
upd_taken  in  1  actual outcome.
upd_target  in  XLEN  actual taken target.
upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
upd_pred_pc  in  XLEN  predicted next PC carried down the pipe.
mispredict  out  1  combinational; upd_valid && actual next PC != upd_pred_pc.
upd_count  out  CNT_W  number of accepted updates.
mispred_count  out  CNT_W  number of accepted mispredicted updates.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target (XLEN), ctr (2 bits).
- Reset (rst=1 at an edge): every valid=0, every ctr=2'b01, upd_count=0, mispred_count=0.
  - Target and tag contents are don't-care after reset.
  - Outputs during and after reset: hit=0, pred_taken=0, pred_pc=fetch_pc+4.
- Lookup is combinational, zero latency, and reads only registered state:
  - hit = valid[index] && tag match.
  - pred_pc = target when pred_taken, else fetch_pc+4; addition wraps modulo 2^XLEN.
- Actual next PC = upd_target if upd_taken, else upd_pc+4.
  - mispredict is asserted regardless of en.
- An update is accepted when en && upd_valid && !clear && !rst:
  - Entry hit, taken: ctr saturating-increments (max 2'b11); target <= upd_target.
  - Entry hit, not taken: ctr saturating-decrements (min 2'b00); target is unchanged.
  - Entry miss, taken: allocate. valid=1, tag written, target=upd_target, ctr=2'b10. Any existing entry at that index is overwritten (direct-mapped).
  - Entry miss, not taken: no table change.
  - upd_count increments, saturating at all-ones.
  - mispred_count increments when mispredict is set, also saturating at all-ones.
- clear (with en=1): all valid<=0 and all ctr<=2'b01 at the edge. Statistics are kept. clear has priority over a same-cycle update, which is dropped and not counted.
- Priority order: rst > en=0 (hold) > clear > update.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry; the new value is visible from the next cycle.
- Reset mid-operation discards all learned state; the first cycle after reset is a clean empty-table lookup.

Test Plan:
- Reset, then fetch_pc=0x0000_0040 → hit=0, pred_taken=0, pred_pc=0x0000_0044; counts=0.
- Update pc=0x40, taken, target=0x100, pred_pc=0x44 → mispredict=1; next cycle fetch 0x40 gives hit=1, pred_taken=1, pred_pc=0x100; upd_count=1, mispred_count=1.
- Three not-taken updates to 0x40: ctr 10→01→00→00 (saturates); hit=1, pred_taken=0, pred_pc=0x44. Four taken updates: ctr reaches 11 and holds.
- Alias with ENTRIES=16: taken update pc=0x440 (same index as 0x40) → fetch 0x40 gives hit=0, fetch 0x440 gives hit=1.
- en=0 with upd_valid=1 for 5 cycles → table and counters unchanged; mispredict still follows its inputs. clear together with an update → all hits drop, update is ignored, counts unchanged.
- CNT_W=4: 20 mispredicted updates → upd_count=mispred_count=15 (saturated). Assert rst mid-sequence → all hit=0 on the next cycle.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: fetch lookup, EX update and statistics bundle for the BTB
interface branch_target_buffer_if #(
  parameter int XLEN = 32,
  parameter int CNT_W = 32
);
  logic en, clear;
  logic [XLEN-1:0] fetch_pc, pred_pc, upd_pc, upd_target, upd_pred_pc;
  logic hit, pred_taken, upd_valid, upd_taken, upd_pred_taken, mispredict;
  logic [CNT_W-1:0] upd_count, mispred_count;
  modport master (
    output en, clear, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
    input hit, pred_taken, pred_pc, mispredict, upd_count, mispred_count
  );
  modport slave (
    input en, clear, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
    output hit, pred_taken, pred_pc, mispredict, upd_count, mispred_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters and update/mispredict statistics
module branch_target_buffer #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W = 32,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [XLEN-1:0] target [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [CNT_W-1:0] upd_count, mispred_count;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [XLEN-1:0] actual_pc;
  logic hit, pred_taken, u_hit, mis, accept, unused;
  always_comb begin
    f_idx = bus.fetch_pc[IDX_W+1:2];
    f_tag = bus.fetch_pc[XLEN-1:IDX_W+2];
    u_idx = bus.upd_pc[IDX_W+1:2];
    u_tag = bus.upd_pc[XLEN-1:IDX_W+2];
    hit = valid[f_idx] && tag[f_idx] == f_tag;
    pred_taken = hit && ctr[f_idx][1];
    u_hit = valid[u_idx] && tag[u_idx] == u_tag;
    actual_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
    mis = bus.upd_valid && actual_pc != bus.upd_pred_pc;
    accept = bus.en && bus.upd_valid && !bus.clear;
  end
  assign bus.hit = hit;
  assign bus.pred_taken = pred_taken;
  assign bus.pred_pc = pred_taken ? target[f_idx] : bus.fetch_pc + XLEN'(4);
  assign bus.mispredict = mis;
  assign bus.upd_count = upd_count;
  assign bus.mispred_count = mispred_count;
  // the carried prediction bit is redundant with upd_pred_pc for mispredict detection
  assign unused = bus.upd_pred_taken;
  always_ff @(posedge clk)
    if (rst || (bus.en && bus.clear)) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      if (rst) begin
        upd_count <= '0;
        mispred_count <= '0;
      end
    end else if (accept) begin
      upd_count <= upd_count + CNT_W'(upd_count != '1);
      mispred_count <= mispred_count + CNT_W'(mis && mispred_count != '1);
      if (u_hit)
        ctr[u_idx] <= bus.upd_taken ? ctr[u_idx] + 2'(ctr[u_idx] != 2'b11)
                                    : ctr[u_idx] - 2'(ctr[u_idx] != 2'b00);
      else if (bus.upd_taken) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx] <= u_tag;
        ctr[u_idx] <= 2'b10;
      end
      if (bus.upd_taken) target[u_idx] <= bus.upd_target;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven scoreboard bench for branch_target_buffer (CNT_W=32 and CNT_W=4 copies)
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_buffer_if #(.XLEN(32), .CNT_W(32)) bi ();
  branch_target_buffer_if #(.XLEN(32), .CNT_W(4)) si ();

  branch_target_buffer #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bi));
  branch_target_buffer #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut_s (.clk(clk), .rst(rst), .bus(si));

  assign si.en = bi.en;
  assign si.clear = bi.clear;
  assign si.fetch_pc = bi.fetch_pc;
  assign si.upd_valid = bi.upd_valid;
  assign si.upd_pc = bi.upd_pc;
  assign si.upd_taken = bi.upd_taken;
  assign si.upd_target = bi.upd_target;
  assign si.upd_pred_taken = bi.upd_pred_taken;
  assign si.upd_pred_pc = bi.upd_pred_pc;

  typedef struct {
    logic en, clr, uv;
    logic [31:0] fpc, upc;
    logic tk;
    logic [31:0] tgt, pin;
    logic e_hit, e_pt;
    logic [31:0] e_ppc;
    logic e_mis;
    int e_uc, e_mc, s_uc, s_mc;
  } vec_t;

  typedef struct {
    logic hit, pt;
    logic [31:0] ppc;
    logic mis;
    int uc, mc, suc, smc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic en, logic clr, logic uv, logic [31:0] fpc, logic [31:0] upc, logic tk,
                              logic [31:0] tgt, logic [31:0] pin, logic h, logic pt, logic [31:0] pp,
                              logic m, int uc, int mc);
    vec_t v;
    v.en = en; v.clr = clr; v.uv = uv; v.fpc = fpc; v.upc = upc; v.tk = tk; v.tgt = tgt; v.pin = pin;
    v.e_hit = h; v.e_pt = pt; v.e_ppc = pp; v.e_mis = m;
    v.e_uc = uc; v.e_mc = mc; v.s_uc = uc; v.s_mc = mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    bi.en = v.en; bi.clear = v.clr; bi.fetch_pc = v.fpc; bi.upd_valid = v.uv; bi.upd_pc = v.upc;
    bi.upd_taken = v.tk; bi.upd_target = v.tgt; bi.upd_pred_pc = v.pin;
    bi.upd_pred_taken = v.pin != v.upc + 32'd4;
    sb.push_back('{v.e_hit, v.e_pt, v.e_ppc, v.e_mis, v.e_uc, v.e_mc, v.s_uc, v.s_mc});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, " hit"}, 32'(bi.hit), 32'(e.hit));
    check({tag, " pred_taken"}, 32'(bi.pred_taken), 32'(e.pt));
    check({tag, " pred_pc"}, bi.pred_pc, e.ppc);
    check({tag, " mispredict"}, 32'(bi.mispredict), 32'(e.mis));
    check({tag, " upd_count"}, bi.upd_count, e.uc);
    check({tag, " mispred_count"}, bi.mispred_count, e.mc);
    check({tag, " small upd_count"}, 32'(si.upd_count), e.suc);
    check({tag, " small mispred_count"}, 32'(si.mispred_count), e.smc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  0,0,'h44,0,0,0));
    tbl.push_back(mk(1,0,1,'h40,'h40,1,'h100,'h44,        0,0,'h44,1,0,0));
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  1,1,'h100,0,1,1));
    tbl.push_back(mk(1,0,1,'h40,'h40,0,'h100,'h100,       1,1,'h100,1,1,1));
    tbl.push_back(mk(1,0,1,'h40,'h40,0,'h100,'h44,        1,0,'h44,0,2,2));
    tbl.push_back(mk(1,0,1,'h40,'h40,0,'h100,'h44,        1,0,'h44,0,3,2));
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  1,0,'h44,0,4,2));
    tbl.push_back(mk(1,0,1,'h40,'h40,1,'h100,'h44,        1,0,'h44,1,4,2));
    tbl.push_back(mk(1,0,1,'h40,'h40,1,'h100,'h44,        1,0,'h44,1,5,3));
    tbl.push_back(mk(1,0,1,'h40,'h40,1,'h100,'h44,        1,1,'h100,1,6,4));
    tbl.push_back(mk(1,0,1,'h40,'h40,1,'h100,'h44,        1,1,'h100,1,7,5));
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  1,1,'h100,0,8,6));
    tbl.push_back(mk(1,0,1,'h40,'h40,0,'h100,'h100,       1,1,'h100,1,8,6));
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  1,1,'h100,0,9,7));
    tbl.push_back(mk(1,0,1,'h440,'h440,1,'h200,'h444,     0,0,'h444,1,9,7));
    tbl.push_back(mk(1,0,0,'h440,0,0,0,0,                 1,1,'h200,0,10,8));
    tbl.push_back(mk(1,0,0,'h40,0,0,0,0,                  0,0,'h44,0,10,8));
    tbl.push_back(mk(1,0,1,'h440,'h40,0,'h100,'h44,       1,1,'h200,0,10,8));
    tbl.push_back(mk(1,0,0,'h440,0,0,0,0,                 1,1,'h200,0,11,8));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,1,'h80,'h80,1,'h300,'h84,      0,0,'h84,1,11,8));
    tbl.push_back(mk(1,0,0,'h80,0,0,0,0,                  0,0,'h84,0,11,8));
    tbl.push_back(mk(1,0,0,'h440,0,0,0,0,                 1,1,'h200,0,11,8));
    tbl.push_back(mk(1,1,1,'h440,'h80,1,'h300,'h84,       1,1,'h200,1,11,8));
    tbl.push_back(mk(1,0,0,'h440,0,0,0,0,                 0,0,'h444,0,11,8));
    tbl.push_back(mk(1,0,0,'h80,0,0,0,0,                  0,0,'h84,0,11,8));
    tbl.push_back(mk(1,0,1,'hFFFF_FFFC,'hFFFF_FFFC,0,0,0, 0,0,0,0,11,8));
    tbl.push_back(mk(1,0,0,'h40,'h10,1,'h999,0,           0,0,'h44,0,12,8));

    rst = 1'b1;
    v = mk(1,0,0,'h40,0,0,0,0,0,0,'h44,0,0,0);
    bi.en = 1'b1; bi.clear = 1'b0; bi.fetch_pc = 'h40; bi.upd_valid = 1'b0; bi.upd_pc = '0;
    bi.upd_taken = 1'b0; bi.upd_target = '0; bi.upd_pred_taken = 1'b0; bi.upd_pred_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

    for (int k = 0; k < 20; k++) begin
      v = mk(1,0,1,'h500,'h500,1,'h600,'h504, k > 0, k > 0, k > 0 ? 'h600 : 'h504, 1, 12 + k, 8 + k);
      v.s_uc = 12 + k > 15 ? 15 : 12 + k;
      v.s_mc = 8 + k > 15 ? 15 : 8 + k;
      apply($sformatf("sat%0d", k), v);
    end
    v = mk(1,0,0,'h500,0,0,0,0, 1,1,'h600,0,32,28);
    v.s_uc = 15; v.s_mc = 15;
    apply("sat_end", v);

    rst = 1'b1;
    bi.upd_valid = 1'b1; bi.upd_pc = 'h700; bi.upd_taken = 1'b1; bi.upd_target = 'h800; bi.upd_pred_pc = 'h704;
    @(posedge clk);
    #1 rst = 1'b0;
    apply("post_rst_a", mk(1,0,0,'h500,0,0,0,0, 0,0,'h504,0,0,0));
    apply("post_rst_b", mk(1,0,0,'h700,0,0,0,0, 0,0,'h704,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
